uart_tx_periph: RTL

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

---
 rtl/uart_tx_periph_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 25 ++
 rtl/uart_tx_periph.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_tx_periph_pkg.sv
// rtl/uart_tx_periph_pkg.sv - shared register map, status bit positions and frame FSM states
package uart_tx_periph_pkg;

    localparam logic [31:0] TXD_OFF = 32'h18;
    localparam logic [31:0] CON_OFF = 32'h20;

    localparam int CON_DONE_BIT = 2;
    localparam int CON_BUSY_BIT = 4;
    localparam int CON_FULL_BIT = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter, tick on the last clock of each period
module uart_baud_tick #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || restart || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with one-deep holding buffer
module uart_tx_periph #(
    parameter int          CLK_FREQ = 50000000,
    parameter int          BAUD     = 9600,
    parameter logic [31:0] BASE     = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] rdata,
    output logic        tx
);
    import uart_tx_periph_pkg::*;

    localparam int          DIV      = CLK_FREQ / BAUD;
    localparam logic [31:0] TXD_ADDR = BASE + TXD_OFF;
    localparam logic [31:0] CON_ADDR = BASE + CON_OFF;

    tx_state_e   r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitcnt;
    logic        r_tx;
    logic [7:0]  r_buf;
    logic        r_buf_full;
    logic        r_tx_done;

    logic        w_sel_txd;
    logic        w_sel_con;
    logic        w_rd_con;
    logic        w_tick;
    logic        w_take;
    logic        w_accept;
    logic [31:0] w_con;
    logic        w_unused;

    assign w_sel_txd = (addr[31:2] == TXD_ADDR[31:2]);
    assign w_sel_con = (addr[31:2] == CON_ADDR[31:2]);
    assign w_rd_con  = MemRead && w_sel_con;
    assign w_unused  = &{1'b0, addr[1:0], wdata[31:8]};

    // Counter is held at zero while idle so every frame starts a fresh bit period.
    uart_baud_tick #(.DIV(DIV)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (r_state == S_IDLE),
        .tick    (w_tick)
    );

    // The buffer drains into the shifter either from idle or at the end of a stop bit;
    // a write landing on that same edge refills the buffer.
    assign w_take   = r_buf_full && ((r_state == S_IDLE) || (r_state == S_STOP && w_tick));
    assign w_accept = MemWrite && w_sel_txd && (!r_buf_full || w_take);

    always_comb begin
        w_con               = '0;
        w_con[CON_DONE_BIT] = r_tx_done;
        w_con[CON_BUSY_BIT] = (r_state != S_IDLE);
        w_con[CON_FULL_BIT] = r_buf_full;
    end

    always_comb begin
        rdata = '0;
        if (MemRead && w_sel_txd) begin
            rdata = {24'd0, r_buf};
        end else if (w_rd_con) begin
            rdata = w_con;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_tx       <= 1'b1;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf <= wdata[7:0];
            end
            r_buf_full <= w_accept || (r_buf_full && !w_take);

            if (r_state == S_STOP && w_tick) begin
                r_tx_done <= 1'b1;
            end else if (w_rd_con) begin
                r_tx_done <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_buf_full) begin
                        r_shift <= r_buf;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx     <= r_shift[0];
                        r_bitcnt <= '0;
                        r_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bitcnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift  <= r_shift >> 1;
                            r_tx     <= r_shift[1];
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_buf_full) begin
                            r_shift <= r_buf;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx = r_tx;

endmodule
